// File: rtl/ram_bus_master.sv
// Valid/ready command front-end that sequences wr_en/rd_en/Addr/Data cycles for the single-port ram.
// Define RAM_MASTER_VERIFY_EN to read back and compare every write (sets sticky verify_err).
module ram_bus_master #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8,
    parameter int RD_LAT = 1
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_wr,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              busy,
    output logic              verify_err,
    output logic              wr_en,
    output logic              rd_en,
    output logic [ADDR_W-1:0] Addr,
    inout  wire  [DATA_W-1:0] Data
);

`ifdef RAM_MASTER_VERIFY_EN
    typedef enum logic [2:0] {IDLE, WR, TURN, RD, VRD} state_t;
`else
    typedef enum logic [2:0] {IDLE, WR, TURN, RD} state_t;
`endif

    localparam logic [2:0] LAST = 3'(RD_LAT);

    state_t             state_q, state_d;
    logic [2:0]         cnt_q, cnt_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic               wr_en_q, wr_en_d;
    logic               rd_en_q, rd_en_d;
    logic               drv_q, drv_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]  rsp_rdata_q, rsp_rdata_d;
`ifdef RAM_MASTER_VERIFY_EN
    logic               verr_q, verr_d;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wr_en_d     = 1'b0;
        rd_en_d     = 1'b0;
        drv_d       = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
`ifdef RAM_MASTER_VERIFY_EN
        verr_d      = verr_q;
`endif
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    addr_d  = cmd_addr;
                    wdata_d = cmd_wdata;
                    cnt_d   = 3'd0;
                    if (cmd_wr) begin
                        state_d = WR;
                        wr_en_d = 1'b1;
                        drv_d   = 1'b1;
                    end else begin
                        state_d = RD;
                        rd_en_d = 1'b1;
                    end
                end
            end
            WR: state_d = TURN;
            TURN: begin
`ifdef RAM_MASTER_VERIFY_EN
                state_d = VRD;
                rd_en_d = 1'b1;
                cnt_d   = 3'd0;
`else
                state_d = IDLE;
`endif
            end
`ifdef RAM_MASTER_VERIFY_EN
            RD, VRD: begin
`else
            RD: begin
`endif
                if (cnt_q == LAST) begin
                    state_d = IDLE;
                    if (state_q == RD) begin
                        rsp_valid_d = 1'b1;
                        rsp_rdata_d = Data;
                    end
`ifdef RAM_MASTER_VERIFY_EN
                    else if (Data != wdata_q) begin
                        verr_d = 1'b1;
                    end
`endif
                end else begin
                    cnt_d   = cnt_q + 3'd1;
                    rd_en_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q     <= IDLE;
            cnt_q       <= 3'd0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wr_en_q     <= 1'b0;
            rd_en_q     <= 1'b0;
            drv_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
`ifdef RAM_MASTER_VERIFY_EN
            verr_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wr_en_q     <= wr_en_d;
            rd_en_q     <= rd_en_d;
            drv_q       <= drv_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
`ifdef RAM_MASTER_VERIFY_EN
            verr_q      <= verr_d;
`endif
        end
    end

    // Drive enable is only ever set alongside wr_en, so the bus is free whenever rd_en is high.
    assign Data      = drv_q ? wdata_q : {DATA_W{1'bz}};
    assign cmd_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign wr_en     = wr_en_q;
    assign rd_en     = rd_en_q;
    assign Addr      = addr_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
`ifdef RAM_MASTER_VERIFY_EN
    assign verify_err = verr_q;
`else
    assign verify_err = 1'b0;
`endif

endmodule

// File: tb/tb_ram_bus_master.sv
// Bench for ram_bus_master: three instances (RD_LAT 0, 1, 3), each with its own ram model and stimulus.
module tb_ram_bus_master;

`ifdef RAM_MASTER_VERIFY_EN
    localparam bit VER = 1'b1;
`else
    localparam bit VER = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input int ln, input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL lane%0d %s got=%0h exp=%0h", ln, tag, got, exp);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_lane
        localparam int L = (g == 0) ? 0 : ((g == 1) ? 1 : 3);

        logic       rst, cv, cw, cr, rv, bsy, verr, we, re;
        logic [3:0] ca, addr;
        logic [7:0] cd, rdat;
        wire  [7:0] dbus;

        logic [7:0] mem [16];
        int         rcnt = 0;
        logic       stuck = 1'b0;
        logic       mon = 1'b0;
        logic       prev_we = 1'b0;
        logic       done = 1'b0;

        logic [7:0] ref_m [16];
        logic [3:0] cur_a;
        logic [7:0] cur_wd;
        logic [7:0] last_rd;
        logic       exp_verr;

        ram_bus_master #(.ADDR_W(4), .DATA_W(8), .RD_LAT(L)) dut (
            .Clk(clk), .Rst(rst), .cmd_valid(cv), .cmd_ready(cr), .cmd_wr(cw),
            .cmd_addr(ca), .cmd_wdata(cd), .rsp_valid(rv), .rsp_rdata(rdat),
            .busy(bsy), .verify_err(verr), .wr_en(we), .rd_en(re), .Addr(addr), .Data(dbus)
        );

        // Ram model: data appears once rd_en has been held for L cycles; optional bit-0 stuck-at-0.
        always @(posedge clk) rcnt <= re ? rcnt + 1 : 0;
        always @(posedge clk) if (we) mem[addr] <= stuck ? (dbus & 8'hFE) : dbus;
        assign dbus = (re && rcnt >= L) ? mem[addr] : 8'hzz;

        always @(negedge clk) begin
            if (mon) begin
                if (we || re) begin
                    chk(g, "en_excl", {31'd0, we & re}, 32'd0);
                    chk(g, "addr", {28'd0, addr}, {28'd0, cur_a});
                end
                if (we) chk(g, "wr_bus", {24'd0, dbus}, {24'd0, cur_wd});
                if (re && rcnt >= L) chk(g, "rd_bus", {24'd0, dbus}, {24'd0, mem[addr]});
                if (prev_we) chk(g, "turn", {30'd0, we, re}, 32'd0);
            end
            prev_we <= we;
        end

        // Presents one command (cv left high) and returns at the negedge where cmd_ready is back.
        task automatic run_cmd(input bit w, input logic [3:0] a, input logic [7:0] d);
            int n, k, nrd, nrsp, rsp_at;
            logic [7:0] got;
            cv = 1'b1; cw = w; ca = a; cd = d;
            n = 0;
            while (!cr && n < 64) begin @(negedge clk); n++; end
            if (!cr) begin chk(g, "accept_timeout", 32'd0, 32'd1); return; end
            @(posedge clk);
            cur_a = a; cur_wd = d;
            #1;
            k = 0; nrd = 0; nrsp = 0; rsp_at = 0; got = 8'h00;
            do begin
                @(negedge clk);
                k++;
                if (re) nrd++;
                if (rv) begin nrsp++; rsp_at = k; got = rdat; end
            end while (!cr && k < 64);
            if (w) begin
                if (VER && stuck && d[0]) exp_verr = 1'b1;
                ref_m[a] = stuck ? (d & 8'hFE) : d;
                chk(g, "wr_lat", k, VER ? 3 + L + 1 : 3);
                chk(g, "wr_rd_cycles", nrd, VER ? L + 1 : 0);
                chk(g, "wr_no_rsp", nrsp, 0);
                chk(g, "rdata_hold", {24'd0, rdat}, {24'd0, last_rd});
            end else begin
                chk(g, "rd_lat", k, L + 2);
                chk(g, "rd_cycles", nrd, L + 1);
                chk(g, "rsp_count", nrsp, 1);
                chk(g, "rsp_at", rsp_at, L + 2);
                chk(g, "rdata", {24'd0, got}, {24'd0, ref_m[a]});
                last_rd = ref_m[a];
            end
            chk(g, "verify_err", {31'd0, verr}, {31'd0, exp_verr});
        endtask

        task automatic do_reset(input int cycles);
            rst = 1'b1; cv = 1'b0;
            repeat (cycles) @(posedge clk);
            #1 rst = 1'b0;
            @(negedge clk);
            exp_verr = 1'b0;
            last_rd  = 8'h00;
        endtask

        initial begin
            int nr;
            cw = 1'b0; ca = 4'h0; cd = 8'h00; cur_a = 4'h0; cur_wd = 8'h00;
            do_reset(3);
            chk(g, "rst_ready", {31'd0, cr}, 32'd1);
            chk(g, "rst_busy", {31'd0, bsy}, 32'd0);
            chk(g, "rst_en", {30'd0, we, re}, 32'd0);
            chk(g, "rst_rsp", {31'd0, rv}, 32'd0);
            chk(g, "rst_rdata", {24'd0, rdat}, 32'd0);
            chk(g, "rst_addr", {28'd0, addr}, 32'd0);
            chk(g, "rst_verr", {31'd0, verr}, 32'd0);
            mon = 1'b1;

            // Reset lands while the write cycle is on the bus; the ram still sees that one cycle.
            cv = 1'b1; cw = 1'b1; ca = 4'h5; cd = 8'h3C; cur_a = 4'h5; cur_wd = 8'h3C;
            @(posedge clk);
            #1 rst = 1'b1; cv = 1'b0;
            @(negedge clk);
            chk(g, "abort_wr_en", {31'd0, we}, 32'd1);
            @(posedge clk); @(posedge clk);
            #1 rst = 1'b0;
            @(negedge clk);
            chk(g, "abort_en", {30'd0, we, re}, 32'd0);
            chk(g, "abort_ready", {31'd0, cr}, 32'd1);
            chk(g, "abort_busy", {31'd0, bsy}, 32'd0);
            nr = 0;
            repeat (6) begin if (rv) nr++; @(negedge clk); end
            chk(g, "abort_no_rsp", nr, 0);
            ref_m[5] = 8'h3C;
            exp_verr = 1'b0; last_rd = 8'h00;

            run_cmd(1'b1, 4'h3, 8'hA5);
            cv = 1'b0; @(negedge clk);
            run_cmd(1'b0, 4'h3, 8'h00);
            cv = 1'b0; @(negedge clk);

            for (int a = 0; a < 16; a++) run_cmd(1'b1, 4'(a), 8'hF0 ^ 8'(a));
            for (int a = 0; a < 16; a++) run_cmd(1'b0, 4'(a), 8'h00);
            cv = 1'b0; @(negedge clk);

            for (int i = 0; i < 20; i++)
                run_cmd((i % 2) == 0, 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
            cv = 1'b0; @(negedge clk);

            for (int i = 0; i < 20; i++) begin
                run_cmd(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
                cv = 1'b0;
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end

            stuck = 1'b1;
            run_cmd(1'b1, 4'h9, 8'h01);
            stuck = 1'b0;
            run_cmd(1'b1, 4'h9, 8'h02);
            run_cmd(1'b0, 4'h9, 8'h00);
            cv = 1'b0;
            do_reset(2);
            chk(g, "verr_cleared", {31'd0, verr}, 32'd0);
            done = 1'b1;
        end
    end

    initial begin
        int c;
        c = 0;
        while (!(g_lane[0].done && g_lane[1].done && g_lane[2].done) && c < 20000) begin
            @(posedge clk);
            c++;
        end
        if (!(g_lane[0].done && g_lane[1].done && g_lane[2].done))
            chk(-1, "global_timeout", 32'd0, 32'd1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ram_bus_master.md
Name: ram_bus_master

Overview:
- Synthesizable initiator for the team's single-port 16x8 `ram` block. It drives that block's `wr_en`, `rd_en`, `Addr` and shared tri-state `Data` bus.
- Converts a valid/ready command interface (read or write, one word per command) into correctly sequenced RAM bus cycles, including write-to-read bus turnaround.
- Returns read data on a one-cycle response strobe. It replaces bench-only task sequencing so other logic can own the RAM.

Parameters:
- ADDR_W, 4, RAM address width.
- DATA_W, 8, RAM data width.
- RD_LAT, 1, RAM read latency in cycles from the first `rd_en` cycle to valid `Data`; legal range 0..7.

Ports:
- Clk  in  1  system clock; all logic on posedge.
- Rst  in  1  synchronous reset, active-high.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  master can accept a command.
- cmd_wr  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_W  target address.
- cmd_wdata  in  DATA_W  write data; ignored for reads.
- rsp_valid  out  1  one-cycle strobe; `rsp_rdata` is valid.
- rsp_rdata  out  DATA_W  captured read data.
- busy  out  1  high whenever the FSM is not in IDLE.
- verify_err  out  1  sticky write-verify mismatch flag; tied 0 without the macro.
- wr_en  out  1  RAM write enable.
- rd_en  out  1  RAM read enable.
- Addr  out  ADDR_W  RAM address.
- Data  inout  DATA_W  shared RAM data bus.

Behaviour:
- Reset (Rst sampled high at posedge):
  - State goes to IDLE.
  - `wr_en`, `rd_en`, `Addr`, `rsp_valid`, `rsp_rdata`, `busy` and `verify_err` all become 0.
  - `Data` is released (high-Z) from that edge.
  - An in-flight command is dropped; no `rsp_valid` is issued for it.
- Output timing:
  - All bus outputs are registered.
  - `Data` is driven only when registered drive-enable is set. That enable is set only in WR, so `wr_en` and `rd_en` are never both 1.
- State IDLE:
  - `cmd_ready` = 1; `wr_en` = `rd_en` = 0; `Data` = Z.
  - Accept occurs when `cmd_valid` && `cmd_ready` at posedge; `cmd_addr` and `cmd_wdata` are latched.
  - Next state is WR if `cmd_wr`, else RD.
- State WR (1 cycle):
  - `wr_en` = 1, `Addr` = latched address, `Data` = latched write data.
  - Next state is TURN.
- State TURN (1 cycle):
  - `wr_en` = `rd_en` = 0; `Data` released.
  - Next state is IDLE.
  - Write accept-to-ready is 3 cycles.
- State RD:
  - `rd_en` = 1 and `Addr` held for RD_LAT+1 cycles, counted by a 3-bit counter.
  - At the posedge ending the last RD cycle: `rsp_rdata` <= `Data`, `rsp_valid` <= 1 for exactly one cycle, `rd_en` <= 0, state goes to IDLE.
  - RD_LAT=1: accept at edge 0, `rd_en` high for cycles 1-2, `rsp_valid` high in cycle 3, `cmd_ready` back in cycle 3.
- `cmd_ready` is 0 outside IDLE. `cmd_valid` held while not ready is not consumed. Back-to-back commands are legal with no idle gap beyond the state sequence.
- Read after write always passes through TURN, so there is no bus contention.
- Address wrap: `Addr` is used as given; no auto-increment. Address 15 is as legal as address 0.
- `rsp_rdata` holds its last value between responses.

Optional Feature:
- Macro: RAM_MASTER_VERIFY_EN.
- With the macro defined:
  - After a write's TURN, the FSM enters VRD instead of IDLE.
  - VRD is identical to RD at the same address, but captured data is compared with the written data and no `rsp_valid` is produced.
  - A mismatch sets `verify_err` = 1, sticky until Rst.
  - `cmd_ready` stays 0 until the verify completes; write accept-to-ready is 3+RD_LAT+1 cycles.
- Without the macro: no VRD state, and `verify_err` is constant 0.

Test Plan:
- Apply Rst for 2 cycles during a write (`wr_en`=1) -> next cycle `wr_en`=`rd_en`=0, `Data`=Z, `cmd_ready`=1, and no `rsp_valid` for the aborted command.
- Write addr 0x3 data 0xA5, then read addr 0x3 -> one-cycle `rsp_valid` with `rsp_rdata`=0xA5, at accept+RD_LAT+2 cycles.
- Write addresses 0..15 with data 0xF0^addr, then read 0..15 -> every `rsp_rdata` matches, including address 15.
- Hold `cmd_valid` high continuously with alternating write/read -> `Data` is never driven while `rd_en`=1, every write-to-read transition shows one TURN cycle with both enables 0, and no command is lost or duplicated.
- Run with RD_LAT=0 and RD_LAT=3 -> `rd_en` is high for 1 and 4 cycles respectively, and the captured data is correct.
- With RAM_MASTER_VERIFY_EN and a RAM model forcing bit 0 stuck at 0, write 0x01 -> `verify_err`=1 stays set, no `rsp_valid` appears, and a later good write leaves `verify_err`=1 until Rst.
